seq_mult_param: RTL and testbench
=================================

Name: seq_mult_param

Overview:
Parametrised radix-2 shift-add sequential multiplier. Successor to the fixed-width unsigned right-shift multiplier: generic operand width, per-operation signed/unsigned mode, and a start/busy/done handshake in place of the level-sensitive load. Sits in the datapath as a multi-cycle arithmetic unit driven by a controller FSM.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled on the clock edge, accepted only when busy=0.
signed_mode  input  1  1 = a, b and product are two's complement; 0 = unsigned; captured with start.
a  input  WIDTH  multiplicand, captured on the accepting edge.
b  input  WIDTH  multiplier, captured on the accepting edge.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when product becomes valid.
product  output  2*WIDTH  result; held stable from done until the next accepted start.

Behaviour:
- Reset: busy=0, done=0, product=0, state=IDLE, counter=0. Async assert, sync-safe deassert. rst mid-operation aborts immediately; no done is produced.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE: edge with start=1:
  - capture magnitudes |a|, |b| (signed_mode=1) or a, b raw (signed_mode=0);
  - capture neg = signed_mode & (a[MSB] ^ b[MSB]);
  - clear accumulator and counter; go to RUN; busy=1.
  - Magnitude is a WIDTH-bit unsigned value, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
- RUN: one multiplier bit per cycle, LSB first. acc = (acc + (mbit ? mcand<<WIDTH : 0)) >> 1, with a carry bit kept so no bit is lost. After WIDTH cycles go to FIX.
- FIX (1 cycle):
  - product <= neg ? -acc : acc (2*WIDTH two's-complement negate);
  - done=1 for this single edge's output cycle; busy=0; return to IDLE.
- Latency: start accepted at edge N -> done high and product valid after edge N+WIDTH+1. Fixed for both modes and all operand values; no early termination.
- product is not updated during RUN. It keeps the previous result until FIX.
- start while busy=1 is ignored (not queued). start held high continuously gives back-to-back operations: the next start is accepted on the edge where done is high (state IDLE). Minimum issue interval is WIDTH+2 cycles.
- signed_mode, a and b are ignored except on the accepting edge.
- Range: unsigned max (2^W-1)^2 fits in 2W bits. Signed extremes -2^(W-1) * -2^(W-1) = 2^(2W-2) fit as a positive 2W-bit signed value. A zero operand gives product 0 with no negative-zero artefact.

Test Plan:
- Reset then idle, WIDTH=8: busy=0, done=0, product=0; start=0 for 20 cycles -> outputs unchanged.
- Unsigned, WIDTH=8, a=255, b=255, start at edge N -> busy high edges N..N+8, done pulse after edge N+9, product=16'hFE01 held until next start.
- Signed, WIDTH=8: a=-128, b=-128 -> 16384 (16'h4000). a=-3, b=5 -> -15 (16'hFFF1). a=0, b=-7 -> 0.
- Handshake: start pulsed at N+3 mid-operation -> ignored, first result unaffected. start held high -> second operation accepted on the done edge, second done exactly 10 cycles after the first.
- Reset mid-op: assert rst at N+4 -> busy=0, product=0 immediately, no done. A new start after release gives the correct result (a=12, b=10 unsigned -> 120).
- Randomised sweep: 1000 random a, b and modes at WIDTH=4, 8, 16 compared against a reference model. Also checks latency = WIDTH+1 and a single-cycle done every time.

Source files
------------

// File: rtl/seq_mult_param.sv
// Radix-2 shift-add sequential multiplier with signed/unsigned mode and a
// start/busy/done handshake. Fixed latency of WIDTH+1 cycles from the accepting edge.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is honoured only on an edge where the unit is IDLE
  // (busy=0); done is a one-cycle pulse, and product holds until the next
  // accepted start.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] product_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   mag_a_d;
  logic [WIDTH-1:0]   mag_b_d;
  logic               neg_d;
  logic [2*WIDTH:0]   sum_d;

  // Magnitudes are WIDTH-bit unsigned, so the most negative operand maps
  // cleanly onto 2^(WIDTH-1).
  always_comb begin
    mag_a_d = (signed_mode && a[WIDTH-1]) ? -a : a;
    mag_b_d = (signed_mode && b[WIDTH-1]) ? -b : b;
    neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    sum_d   = {1'b0, acc_q} +
              (mplier_q[0] ? {1'b0, mcand_q, {WIDTH{1'b0}}} : {(2*WIDTH+1){1'b0}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= mag_a_d;
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          // The extra top bit of sum_d is the carry, shifted back into acc.
          acc_q    <= sum_d[2*WIDTH:1];
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          product_q <= neg_q ? -acc_q : acc_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: vector table at WIDTH=8, handshake and
// reset corner sequences, and an exhaustive WIDTH=4 sweep against integer multiply.
module tb_seq_mult_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        start, signed_mode;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;
  logic [1:0]  state8;

  seq_mult_param #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product), .state_o(state8)
  );

  // WIDTH=4 instance
  logic       start4, sm4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [7:0] product4;
  logic [1:0] state4;

  seq_mult_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4), .state_o(state4)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sm;
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  // ---------------- driver tasks ----------------
  task automatic issue(input logic sm, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    start = 1'b1; signed_mode = sm; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; signed_mode = ~sm; a = ~av; b = ~bv;
  endtask

  // Counts edges (starting from 'already') until done is seen; -1 on timeout.
  task automatic wait_done(input int already, output int lat);
    int n;
    n = already;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) lat = n;
    end
  endtask

  task automatic run8(input string name, input logic sm, input logic [7:0] av,
                      input logic [7:0] bv, input logic [15:0] exp);
    int lat;
    issue(sm, av, bv);
    check({name, " busy"}, busy, 1);
    wait_done(0, lat);
    check({name, " latency"}, lat, 9);
    check({name, " product"}, product, exp);
    @(posedge clk); #1;
    check({name, " done width"}, done, 0);
  endtask

  task automatic run4(input logic sm, input logic [3:0] av, input logic [3:0] bv,
                      input logic [7:0] exp);
    int lat;
    lat = -1;
    @(negedge clk);
    start4 = 1'b1; sm4 = sm; a4 = av; b4 = bv;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done4) lat = i;
    end
    check($sformatf("w4 %0d:%0h*%0h latency", sm, av, bv), lat, 5);
    check($sformatf("w4 %0d:%0h*%0h product", sm, av, bv), product4, exp);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, lat2;
    logic seen;
    logic [15:0] prev;

    vecs[0]  = '{1'b0, 8'd255, 8'd255, 16'hFE01};
    vecs[1]  = '{1'b0, 8'd12,  8'd10,  16'h0078};
    vecs[2]  = '{1'b0, 8'd0,   8'd200, 16'h0000};
    vecs[3]  = '{1'b0, 8'd1,   8'd255, 16'h00FF};
    vecs[4]  = '{1'b0, 8'd128, 8'd2,   16'h0100};
    vecs[5]  = '{1'b0, 8'hFF,  8'h80,  16'h7F80};
    vecs[6]  = '{1'b0, 8'hFD,  8'h05,  16'h04F1};
    vecs[7]  = '{1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[8]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
    vecs[9]  = '{1'b1, 8'h00,  8'hF9,  16'h0000};
    vecs[10] = '{1'b1, 8'h7F,  8'h80,  16'hC080};
    vecs[11] = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
    vecs[12] = '{1'b1, 8'h07,  8'h06,  16'h002A};
    vecs[13] = '{1'b1, 8'hFF,  8'h02,  16'hFFFE};

    rst = 1'b1;
    start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 0);
    check("reset state", state8, 0);
    rst = 1'b0;

    // Idle with start low: nothing should move.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy || done || product != 16'h0) seen = 1'b1;
    end
    check("idle quiet", seen, 0);

    for (int i = 0; i < 14; i++) begin
      run8($sformatf("vec%0d", i), vecs[i].sm, vecs[i].av, vecs[i].bv, vecs[i].exp);
    end

    // Result holds while idle.
    repeat (5) @(posedge clk);
    #1 check("product hold", product, 16'hFFFE);

    // Mid-operation start is ignored; product keeps old value during RUN.
    prev = product;
    issue(1'b0, 8'd255, 8'd255);
    check("run busy", busy, 1);
    repeat (3) @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 8'd3; b = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("run product held", product, prev);
    wait_done(3, lat);
    check("ignored start latency", lat, 9);
    check("ignored start product", product, 16'hFE01);
    @(posedge clk); #1;
    check("ignored start not queued", busy, 0);

    // start held high: second op accepted on the done edge.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 8'd2; b = 8'd3;
    @(posedge clk); #1;
    wait_done(0, lat);
    check("b2b first latency", lat, 9);
    check("b2b first product", product, 16'd6);
    @(negedge clk);
    a = 8'd5; b = 8'd7;
    wait_done(0, lat2);
    check("b2b interval", lat2, 10);
    check("b2b second product", product, 16'd35);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("b2b stops", busy, 0);

    // Reset mid-operation aborts with no done.
    issue(1'b0, 8'd100, 8'd100);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort product", product, 0);
    check("abort state", state8, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("abort no done", seen, 0);
    run8("after abort", 1'b0, 8'd12, 8'd10, 16'd120);

    // Exhaustive WIDTH=4 sweep against integer multiplication.
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          logic [3:0] xa, yb;
          int xi, yi, p;
          xa = 4'(x); yb = 4'(y);
          xi = (m == 1) ? int'($signed(xa)) : int'(xa);
          yi = (m == 1) ? int'($signed(yb)) : int'(yb);
          p  = xi * yi;
          run4(m[0], xa, yb, 8'(p));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
